// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered UART transmitter, single clock domain.
// Bit timing comes from a baud counter, not a derived clock. Frames from the
// write FIFO are sent back-to-back with no idle gap between them.
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   din        word to transmit, sampled on an accepted write
//   wen        write strobe, accepted only while ready=1
//   ready      FIFO has room (combinational from the registered count)
//   busy       a frame is on the line (start bit through last stop bit)
//   fifo_count words buffered, excluding the frame in flight
//   tx_out     registered serial line, idle high
module uart_tx_fifo #(
    parameter int unsigned CLKS_PER_BIT = 1085,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DATA_BITS-1:0]          din,
    input  logic                          wen,
    output logic                          ready,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          tx_out
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned BIT_W  = 4;

    // Elaboration-time parameter legality
    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
        $error("uart_tx_fifo: CLKS_PER_BIT must be >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_fifo: DATA_BITS must be 5..9");
    end
    if (PARITY > 2) begin : g_bad_parity
        $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP
    } state_t;

    state_t                 r_state;
    logic [BAUD_W-1:0]      r_baud;
    logic [BIT_W-1:0]       r_bit;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_par;
    logic                   r_busy;
    logic                   r_tx;
    logic [CNT_W-1:0]       r_count;
    logic [PTR_W-1:0]       r_wr_ptr;
    logic [PTR_W-1:0]       r_rd_ptr;
    logic [DATA_BITS-1:0]   r_mem [FIFO_DEPTH];

    logic                   w_push;
    logic                   w_pop;
    logic                   w_baud_end;
    logic                   w_stop_end;
    logic [DATA_BITS-1:0]   w_head;
    logic                   w_head_par;

    assign ready      = (r_count != CNT_W'(FIFO_DEPTH));
    assign busy       = r_busy;
    assign fifo_count = r_count;
    assign tx_out     = r_tx;

    // Pop happens when idle with data, or on the last cycle of the last stop bit
    always_comb begin
        w_push     = wen & ready;
        w_baud_end = (r_baud == BAUD_W'(CLKS_PER_BIT - 1));
        w_stop_end = (r_state == S_STOP) && w_baud_end && (r_bit == BIT_W'(STOP_BITS - 1));
        w_pop      = (r_count != '0) && ((r_state == S_IDLE) || w_stop_end);
        w_head     = r_mem[r_rd_ptr];
        // Odd parity inverts the XOR so the total count of ones comes out odd
        w_head_par = (PARITY == 1) ? ~(^w_head) : (^w_head);
    end

    // FIFO storage; flushed by pointer reset only
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Frame sequencer with registered line, busy and counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_busy  <= 1'b0;
            r_tx    <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_tx   <= 1'b1;
                    r_busy <= 1'b0;
                    if (w_pop) begin
                        r_shift <= w_head;
                        r_par   <= w_head_par;
                        r_state <= S_START;
                        r_tx    <= 1'b0;
                        r_busy  <= 1'b1;
                        r_baud  <= '0;
                        r_bit   <= '0;
                    end
                end

                S_START: begin
                    if (w_baud_end) begin
                        r_baud  <= '0;
                        r_bit   <= '0;
                        r_state <= S_DATA;
                        r_tx    <= r_shift[0];
                        r_shift <= r_shift >> 1;
                    end else begin
                        r_baud <= r_baud + BAUD_W'(1);
                    end
                end

                S_DATA: begin
                    if (w_baud_end) begin
                        r_baud <= '0;
                        if (r_bit == BIT_W'(DATA_BITS - 1)) begin
                            r_bit <= '0;
                            if (PARITY != 0) begin
                                r_state <= S_PAR;
                                r_tx    <= r_par;
                            end else begin
                                r_state <= S_STOP;
                                r_tx    <= 1'b1;
                            end
                        end else begin
                            r_bit   <= r_bit + BIT_W'(1);
                            r_tx    <= r_shift[0];
                            r_shift <= r_shift >> 1;
                        end
                    end else begin
                        r_baud <= r_baud + BAUD_W'(1);
                    end
                end

                S_PAR: begin
                    if (w_baud_end) begin
                        r_baud  <= '0;
                        r_bit   <= '0;
                        r_state <= S_STOP;
                        r_tx    <= 1'b1;
                    end else begin
                        r_baud <= r_baud + BAUD_W'(1);
                    end
                end

                S_STOP: begin
                    if (w_baud_end) begin
                        r_baud <= '0;
                        if (w_stop_end) begin
                            r_bit <= '0;
                            // Chain straight into the next start bit when data is waiting
                            if (w_pop) begin
                                r_shift <= w_head;
                                r_par   <= w_head_par;
                                r_state <= S_START;
                                r_tx    <= 1'b0;
                                r_busy  <= 1'b1;
                            end else begin
                                r_state <= S_IDLE;
                                r_tx    <= 1'b1;
                                r_busy  <= 1'b0;
                            end
                        end else begin
                            r_bit <= r_bit + BIT_W'(1);
                        end
                    end else begin
                        r_baud <= r_baud + BAUD_W'(1);
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench: instance 0 is 8N1, instance 1 is 7O2, instance 2 is 7E2,
// all with CLKS_PER_BIT=4 and FIFO_DEPTH=4. Stimulus pushes expected frames;
// per-instance line monitors decode tx_out and compare.
module tb_uart_tx_fifo;

    localparam int CPB = 4;

    typedef struct {
        int          idx;
        logic [15:0] bits;
    } exp_t;

    logic        clk;
    logic [2:0]  rst_v;
    logic [2:0]  wen_v;
    logic [7:0]  din0;
    logic [6:0]  din1;
    logic [6:0]  din2;
    logic [2:0]  ready_w;
    logic [2:0]  busy_w;
    logic [2:0]  tx_w;
    logic [2:0]  cnt_w [3];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    exp_t sb[$];

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut0 (
        .clk(clk), .rst_n(rst_v[0]), .din(din0), .wen(wen_v[0]),
        .ready(ready_w[0]), .busy(busy_w[0]), .fifo_count(cnt_w[0]), .tx_out(tx_w[0]));

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) u_dut1 (
        .clk(clk), .rst_n(rst_v[1]), .din(din1), .wen(wen_v[1]),
        .ready(ready_w[1]), .busy(busy_w[1]), .fifo_count(cnt_w[1]), .tx_out(tx_w[1]));

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) u_dut2 (
        .clk(clk), .rst_n(rst_v[2]), .din(din2), .wen(wen_v[2]),
        .ready(ready_w[2]), .busy(busy_w[2]), .fifo_count(cnt_w[2]), .tx_out(tx_w[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Frame images, LSB = start bit
    function automatic logic [15:0] f8(input logic [7:0] d);
        return {6'b0, 1'b1, d, 1'b0};
    endfunction

    function automatic logic [15:0] f7(input logic [6:0] d, input logic p);
        return {5'b0, 2'b11, p, d, 1'b0};
    endfunction

    task automatic push(input int idx, input logic [8:0] d, output int en);
        din0 = d[7:0];
        din1 = d[6:0];
        din2 = d[6:0];
        wen_v[idx] = 1'b1;
        @(posedge clk);
        #1;
        wen_v = '0;
        en = cyc;
    endtask

    task automatic wait_until(input int t);
        @(negedge clk);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic wait_busy_low(input int idx, input int limit, output int at);
        int n;
        n = 0;
        @(negedge clk);
        while (busy_w[idx] !== 1'b0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (busy_w[idx] !== 1'b0) check("busy_low_timeout", 32'(busy_w[idx]), 32'd0);
        at = cyc;
    endtask

    // Line monitor: samples every cycle of a frame so bit length is exact
    task automatic monitor(input int idx);
        int          nb;
        logic [15:0] bits;
        logic        stable;
        logic        aborted;
        exp_t        e;
        nb = (idx == 0) ? 10 : 11;
        forever begin
            @(negedge clk);
            if (rst_v[idx] === 1'b1 && tx_w[idx] === 1'b0) begin
                bits    = '0;
                stable  = 1'b1;
                aborted = 1'b0;
                for (int b = 0; b < nb; b++) begin
                    for (int s = 0; s < CPB; s++) begin
                        if (b != 0 || s != 0) @(negedge clk);
                        if (rst_v[idx] !== 1'b1) aborted = 1'b1;
                        else if (!aborted) begin
                            if (s == 0) bits[b] = tx_w[idx];
                            else if (tx_w[idx] !== bits[b]) stable = 1'b0;
                        end
                    end
                end
                if (!aborted) begin
                    if (sb.size() == 0) begin
                        check("unexpected_frame", 32'(bits), 32'hFFFF_FFFF);
                    end else begin
                        e = sb.pop_front();
                        check("frame_inst", 32'(idx), 32'(e.idx));
                        check("frame_bits", 32'(bits), 32'(e.bits));
                        check("bit_width_stable", 32'(stable), 32'd1);
                    end
                end
            end
        end
    endtask

    initial monitor(0);
    initial monitor(1);
    initial monitor(2);

    initial begin
        int n, s, at, bad_tx, bad_busy, bad_rdy, bad_cnt;
        logic [6:0] pv [4];
        logic       po [4];
        logic       pe [4];

        rst_v = '0;
        wen_v = '0;
        din0  = '0;
        din1  = '0;
        din2  = '0;

        // Reset and idle
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx_w[0]), 32'd1);
        check("rst_busy", 32'(busy_w[0]), 32'd0);
        check("rst_ready", 32'(ready_w[0]), 32'd1);
        check("rst_count", 32'(cnt_w[0]), 32'd0);
        rst_v = 3'b111;
        bad_tx = 0; bad_busy = 0; bad_rdy = 0; bad_cnt = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx_w[0] !== 1'b1) bad_tx++;
            if (busy_w[0] !== 1'b0) bad_busy++;
            if (ready_w[0] !== 1'b1) bad_rdy++;
            if (cnt_w[0] !== 3'd0) bad_cnt++;
        end
        check("idle_tx_cycles_bad", 32'(bad_tx), 32'd0);
        check("idle_busy_cycles_bad", 32'(bad_busy), 32'd0);
        check("idle_ready_cycles_bad", 32'(bad_rdy), 32'd0);
        check("idle_count_cycles_bad", 32'(bad_cnt), 32'd0);

        // Single 8N1 frame: 0xA5
        sb.push_back('{0, 16'b0000_0011_0100_1010});
        push(0, 9'h0A5, n);
        check("a5_count_after_push", 32'(cnt_w[0]), 32'd1);
        wait_until(n + 1);
        check("a5_start_tx", 32'(tx_w[0]), 32'd0);
        check("a5_start_busy", 32'(busy_w[0]), 32'd1);
        check("a5_start_count", 32'(cnt_w[0]), 32'd0);
        wait_busy_low(0, 100, at);
        check("a5_busy_fall_cycle", 32'(at - n), 32'd41);

        // Burst of six into depth-4 FIFO; sixth is dropped
        sb.push_back('{0, f8(8'h11)});
        sb.push_back('{0, f8(8'h22)});
        sb.push_back('{0, f8(8'h33)});
        sb.push_back('{0, f8(8'h44)});
        sb.push_back('{0, f8(8'h55)});
        push(0, 9'h011, n);
        push(0, 9'h022, at);
        push(0, 9'h033, at);
        push(0, 9'h044, at);
        push(0, 9'h055, at);
        check("burst_ready_full", 32'(ready_w[0]), 32'd0);
        check("burst_count_full", 32'(cnt_w[0]), 32'd4);
        push(0, 9'h066, at);
        check("burst_count_after_drop", 32'(cnt_w[0]), 32'd4);
        s = n + 1;
        for (int k = 1; k <= 4; k++) begin
            wait_until(s + 40 * k - 1);
            check("burst_stop_tx", 32'(tx_w[0]), 32'd1);
            wait_until(s + 40 * k);
            check("burst_start_tx", 32'(tx_w[0]), 32'd0);
            check("burst_start_busy", 32'(busy_w[0]), 32'd1);
            check("burst_start_count", 32'(cnt_w[0]), 32'(4 - k));
        end
        wait_until(s + 200);
        check("burst_end_busy", 32'(busy_w[0]), 32'd0);

        // Push on the same edge as the end-of-stop pop, count = 2
        sb.push_back('{0, f8(8'hA1)});
        sb.push_back('{0, f8(8'hB2)});
        sb.push_back('{0, f8(8'hC3)});
        sb.push_back('{0, f8(8'hD4)});
        push(0, 9'h0A1, n);
        push(0, 9'h0B2, at);
        push(0, 9'h0C3, at);
        s = n + 1;
        wait_until(s + 39);
        check("simul_count_before", 32'(cnt_w[0]), 32'd2);
        check("simul_stop_tx", 32'(tx_w[0]), 32'd1);
        push(0, 9'h0D4, at);
        check("simul_count_after", 32'(cnt_w[0]), 32'd2);
        check("simul_start_tx", 32'(tx_w[0]), 32'd0);
        wait_busy_low(0, 400, at);

        // 7O2 and 7E2 frames; parity bits hand-computed
        pv[0] = 7'h03; po[0] = 1'b1; pe[0] = 1'b0;
        pv[1] = 7'h7F; po[1] = 1'b0; pe[1] = 1'b1;
        pv[2] = 7'h00; po[2] = 1'b1; pe[2] = 1'b0;
        pv[3] = 7'h2A; po[3] = 1'b0; pe[3] = 1'b1;

        sb.push_back('{1, 16'b0000_0111_0000_0110});
        push(1, 9'h003, n);
        wait_until(n + 1);
        check("odd_start_tx", 32'(tx_w[1]), 32'd0);
        wait_busy_low(1, 100, at);
        check("odd_frame_len", 32'(at - n - 1), 32'd44);

        for (int i = 0; i < 4; i++) sb.push_back('{1, f7(pv[i], po[i])});
        push(1, {2'b0, pv[0]}, n);
        for (int i = 1; i < 4; i++) push(1, {2'b0, pv[i]}, at);
        wait_busy_low(1, 400, at);
        check("odd_burst_len", 32'(at - n - 1), 32'd176);

        for (int i = 0; i < 4; i++) sb.push_back('{2, f7(pv[i], pe[i])});
        push(2, {2'b0, pv[0]}, n);
        for (int i = 1; i < 4; i++) push(2, {2'b0, pv[i]}, at);
        wait_busy_low(2, 400, at);
        check("even_burst_len", 32'(at - n - 1), 32'd176);

        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        // Mid-frame reset during DATA of a 0x00 frame, second word queued
        push(0, 9'h000, n);
        push(0, 9'h000, at);
        wait_until(n + 12);
        check("mrst_pre_tx", 32'(tx_w[0]), 32'd0);
        check("mrst_pre_count", 32'(cnt_w[0]), 32'd1);
        #1;
        rst_v[0] = 1'b0;
        #1;
        check("mrst_tx", 32'(tx_w[0]), 32'd1);
        check("mrst_count", 32'(cnt_w[0]), 32'd0);
        check("mrst_busy", 32'(busy_w[0]), 32'd0);
        repeat (3) @(negedge clk);
        rst_v[0] = 1'b1;
        bad_tx = 0; bad_busy = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx_w[0] !== 1'b1) bad_tx++;
            if (busy_w[0] !== 1'b0) bad_busy++;
        end
        check("post_rst_tx_cycles_bad", 32'(bad_tx), 32'd0);
        check("post_rst_busy_cycles_bad", 32'(bad_busy), 32'd0);
        check("post_rst_count", 32'(cnt_w[0]), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised, FIFO-buffered UART transmitter. It is the next generation of the team's single-byte transmitter.
- Runs entirely in the clk domain; no derived clocks. Bit timing comes from a clock-enable counter.
- Configurable data width, parity mode and stop-bit count.
- A small write FIFO accepts bursts from upstream logic (e.g. result formatter) and sends frames back-to-back on the serial line.

Parameters:
CLKS_PER_BIT, 1085, clk cycles per serial bit (125 MHz / 115200); legal >= 2
DATA_BITS, 8, payload bits per frame; legal 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, stop bits per frame; legal 1 or 2
FIFO_DEPTH, 4, write-buffer entries; power of two, >= 2

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous, active-low reset
din  input  DATA_BITS  data word to transmit
wen  input  1  write strobe; accepted only when ready=1
ready  output  1  FIFO can accept a word (fifo_count < FIFO_DEPTH)
busy  output  1  a frame is on the line (start bit through last stop bit)
fifo_count  output  $clog2(FIFO_DEPTH)+1  words buffered, not counting the frame in flight
tx_out  output  1  serial line, idle high

Behaviour:
- Single clock domain; reset asynchronous, active-low.
- Reset values: tx_out=1, busy=0, fifo_count=0, ready=1. FIFO pointers and FSM go to IDLE; bit counter and baud counter clear to 0.
- Push: at a rising edge with wen=1 and ready=1, din is written to the FIFO and fifo_count increments.
- wen while ready=0 is ignored; the word is dropped and no state changes.
- din is sampled only at push; later changes have no effect.
- ready is combinational from the registered count: ready = (fifo_count != FIFO_DEPTH).
- Push and pop on the same edge (possible only when not full) leave fifo_count unchanged.
- FSM states are IDLE, START, DATA, PAR, STOP. Every state except IDLE holds each bit for exactly CLKS_PER_BIT cycles, using a baud counter 0..CLKS_PER_BIT-1.
  - IDLE: tx_out=1, busy=0. If fifo_count != 0 at an edge: pop into the shift register, enter START, drive tx_out=0, set busy=1, clear the baud counter.
  - Latency: a word pushed into an empty FIFO while IDLE at edge N gives tx_out=0 from edge N+1.
  - START: drive 0. After CLKS_PER_BIT cycles go to DATA.
  - DATA: send DATA_BITS bits, LSB first. After the last bit go to PAR if PARITY != 0, else STOP.
  - PAR: drive the parity bit. Odd parity makes the total count of 1s across data and parity odd; even parity makes it even. Parity is computed from the popped word.
  - STOP: drive 1 for STOP_BITS*CLKS_PER_BIT cycles.
- End of last stop-bit cycle:
  - If the FIFO is non-empty, pop and enter START on that same edge. There is no idle gap between frames.
  - Otherwise go to IDLE and set busy=0.
- Frame length = CLKS_PER_BIT * (1 + DATA_BITS + (PARITY != 0) + STOP_BITS) cycles exactly.
- tx_out is a registered output; no glitches.
- Reset asserted mid-frame: tx_out goes to 1 immediately (asynchronous). The FIFO is flushed, the frame is abandoned and is not resumed after reset.
- Illegal parameter values are flagged at elaboration (generate-time $error); no runtime checking.

Test Plan:
- Reset/idle: CLKS_PER_BIT=4, hold rst_n=0 then release, no wen → tx_out=1, busy=0, ready=1, fifo_count=0 for 100 cycles.
- Single frame 8N1: CLKS_PER_BIT=4, push 0xA5 at edge N.
  - tx_out=0 for edges N+1..N+4, then bits 1,0,1,0,0,1,0,1 (4 cycles each), then 1 for 4 cycles.
  - busy falls at N+41.
- Parity/stop: DATA_BITS=7, PARITY=1, STOP_BITS=2, push 0x03.
  - Frame is start 0, data 1,1,0,0,0,0,0, parity 1, stop 1,1; 11 bits × CLKS_PER_BIT.
  - With PARITY=2 the parity bit is 0.
- Burst/full: FIFO_DEPTH=4, push 6 words on consecutive cycles while IDLE.
  - Words 1–5 are accepted: the first is popped, leaving 4 in the FIFO, and ready=0 at the 6th edge.
  - Word 6 is dropped.
  - Five frames are sent back-to-back with no idle cycle between stop and start; fifo_count decrements at each frame start.
- Simultaneous push/pop: push on the exact edge the FSM pops at the end of a stop bit with fifo_count=2 → fifo_count stays 2 and the next frame starts that edge.
- Mid-frame reset: assert rst_n=0 during DATA of a 0x00 frame → tx_out=1 within the same cycle, fifo_count=0. After release, no frame is transmitted.
